clock_supervisor: RTL and testbench

//  Parametrised reset/lock sequencer for NUM_GEN clock generators (DCM_SP instances), running on the raw clk48 input.

---
 rtl/clock_supervisor_pkg.sv | 18 +
 rtl/clock_supervisor_lock_sync_debounce.sv | 44 ++++
 rtl/clock_supervisor.sv | 170 +++++++++++++++++
 tb/tb_clock_supervisor.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_supervisor_pkg.sv
// Shared state encoding, fixed output widths and helpers for the clock supervisor.
package clock_supervisor_pkg;

  typedef enum logic [1:0] {
    SUP_RESET = 2'b00,
    SUP_WAIT  = 2'b01,
    SUP_RUN   = 2'b10,
    SUP_FAIL  = 2'b11
  } sup_state_e;

  localparam int unsigned LOST_W  = 8;
  localparam int unsigned RETRY_W = 2;

  function automatic logic [LOST_W-1:0] sat_inc(input logic [LOST_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/clock_supervisor_lock_sync_debounce.sv
// Per-channel LOCKED synchroniser and debouncer: stable after STABLE_CYCLES
// consecutive synced-high cycles, dropped on the first synced low.
module lock_sync_debounce #(
  parameter int unsigned STABLE_CYCLES = 16
) (
  input  logic clk48,
  input  logic clkgen_rst,
  input  logic locked_async,
  output logic stable
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  logic             sync1_q;
  logic             sync2_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!sync2_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk48) begin
    if (clkgen_rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= locked_async;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
    end
  end

  // Gating with sync2_q makes stable fall on the very first synced low.
  assign stable = sync2_q && (cnt_q == CNT_MAX);

endmodule

// File: rtl/clock_supervisor.sv
// Reset/lock sequencer for NUM_GEN clock generators: pulses DCM resets, waits for
// debounced locks with retry, re-sequences on lock loss and commits the fast-clock select.
module clock_supervisor
  import clock_supervisor_pkg::*;
#(
  parameter int unsigned NUM_GEN      = 4,
  parameter int unsigned RST_HOLD     = 8,
  parameter int unsigned LOCK_TIMEOUT = 65536,
  parameter int unsigned LOCK_STABLE  = 16,
  parameter int unsigned MAX_RETRY    = 3,
  parameter int unsigned SEL_W        = 1,
  parameter int unsigned SEL_GAP      = 4
) (
  input  logic               clk48,
  input  logic               clkgen_rst,
  input  logic [NUM_GEN-1:0] gen_enable,
  input  logic [NUM_GEN-1:0] gen_locked,
  input  logic               restart,
  input  logic [SEL_W-1:0]   sel_req,
  output logic [NUM_GEN-1:0] dcm_rst,
  output logic               clocks_locked,
  output logic [SEL_W-1:0]   fastclk_sel,
  output logic [1:0]         sup_state,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic [LOST_W-1:0]  lost_cnt
);

  localparam int unsigned HOLD_W = $clog2(RST_HOLD + 1);
  localparam int unsigned TMR_W  = $clog2(LOCK_TIMEOUT + 1);
  localparam int unsigned RTY_W  = $clog2(MAX_RETRY + 1);
  localparam int unsigned GAP_W  = $clog2(SEL_GAP + 1);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [RTY_W-1:0]  RTY_MAX   = RTY_W'(MAX_RETRY);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(SEL_GAP - 1);

  logic [NUM_GEN-1:0] stable;

  for (genvar g = 0; g < NUM_GEN; g++) begin : g_lock
    lock_sync_debounce #(
      .STABLE_CYCLES(LOCK_STABLE)
    ) u_lsd (
      .clk48       (clk48),
      .clkgen_rst  (clkgen_rst),
      .locked_async(gen_locked[g]),
      .stable      (stable[g])
    );
  end

  sup_state_e         state_q, state_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [RTY_W-1:0]   retry_q, retry_d;
  logic [LOST_W-1:0]  lost_q, lost_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   sel_prev_q;
  logic [NUM_GEN-1:0] en_q;
  logic [NUM_GEN-1:0] dcm_rst_q;
  logic               locked_q;

  logic all_ok;
  logic run_ok;
  logic sel_changed;

  assign all_ok      = &(stable | ~gen_enable);
  // Loss in RUN is judged against the mask RUN was entered with, so a mask
  // change alone re-sequences without being counted as a lock loss.
  assign run_ok      = &(stable | ~en_q);
  assign sel_changed = (sel_req != sel_prev_q);

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    timer_d = timer_q;
    retry_d = retry_q;
    lost_d  = lost_q;
    unique case (state_q)
      SUP_RESET: begin
        if (gen_enable == '0) begin
          hold_d = '0;
        end else if (hold_q == HOLD_LAST) begin
          hold_d  = '0;
          state_d = SUP_WAIT;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      SUP_WAIT: begin
        if (all_ok) begin
          timer_d = '0;
          retry_d = '0;
          state_d = SUP_RUN;
        end else if (timer_q == TMR_LAST) begin
          timer_d = '0;
          retry_d = retry_q + 1'b1;
          state_d = (retry_d == RTY_MAX) ? SUP_FAIL : SUP_RESET;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      SUP_RUN: begin
        if (!run_ok || (gen_enable != en_q) || restart) begin
          state_d = SUP_RESET;
        end
        if (!run_ok) begin
          lost_d = sat_inc(lost_q);
        end
      end
      SUP_FAIL: begin
        if (restart) begin
          retry_d = '0;
          state_d = SUP_RESET;
        end
      end
      default: state_d = SUP_RESET;
    endcase
  end

  always_comb begin
    gap_d = '0;
    sel_d = sel_q;
    if ((state_q == SUP_RUN) && (sel_req != sel_q)) begin
      if (!sel_changed) begin
        gap_d = gap_q + 1'b1;
      end
      if (gap_d == GAP_LAST) begin
        sel_d = sel_req;
        gap_d = '0;
      end
    end
  end

  always_ff @(posedge clk48) begin
    if (clkgen_rst) begin
      state_q    <= SUP_RESET;
      hold_q     <= '0;
      timer_q    <= '0;
      retry_q    <= '0;
      lost_q     <= '0;
      gap_q      <= '0;
      sel_q      <= '0;
      sel_prev_q <= '0;
      en_q       <= gen_enable;
      dcm_rst_q  <= '1;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      timer_q    <= timer_d;
      retry_q    <= retry_d;
      lost_q     <= lost_d;
      gap_q      <= gap_d;
      sel_q      <= sel_d;
      sel_prev_q <= sel_req;
      en_q       <= gen_enable;
      dcm_rst_q  <= ((state_d == SUP_RESET) || (state_d == SUP_FAIL)) ? '1 : ~gen_enable;
      locked_q   <= (state_d == SUP_RUN);
    end
  end

  assign sup_state     = state_q;
  assign dcm_rst       = dcm_rst_q;
  assign clocks_locked = locked_q;
  assign fastclk_sel   = sel_q;
  assign retry_cnt     = RETRY_W'(retry_q);
  assign lost_cnt      = lost_q;

endmodule

// File: tb/tb_clock_supervisor.sv
// Bench for clock_supervisor: scripted vector table, hand sequences for multi-cycle
// corners, and random stimulus checked every cycle against a behavioural model.
module tb_clock_supervisor;

  localparam int HOLD = 8;
  localparam int TOUT = 64;
  localparam int STAB = 16;
  localparam int MRET = 3;
  localparam int GAP  = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] en;
  logic [3:0] lk;
  logic       restart;
  logic [0:0] selr;
  logic [3:0] dcm;
  logic       cl;
  logic [0:0] fsel;
  logic [1:0] st;
  logic [1:0] rc;
  logic [7:0] lc;

  always #5 clk = ~clk;

  clock_supervisor #(
    .NUM_GEN(4), .RST_HOLD(HOLD), .LOCK_TIMEOUT(TOUT), .LOCK_STABLE(STAB),
    .MAX_RETRY(MRET), .SEL_W(1), .SEL_GAP(GAP)
  ) dut (
    .clk48(clk), .clkgen_rst(rst), .gen_enable(en), .gen_locked(lk),
    .restart(restart), .sel_req(selr), .dcm_rst(dcm), .clocks_locked(cl),
    .fastclk_sel(fsel), .sup_state(st), .retry_cnt(rc), .lost_cnt(lc)
  );

  int total = 0;
  int bad   = 0;

  // Behavioural model: states 0 RESET, 1 WAIT, 2 RUN, 3 FAIL; age = cycles in state.
  int         m_st, m_age, m_retry, m_lost, m_runedges, m_selage;
  bit         m_sel, m_prev_sel, m_cl;
  logic [3:0] m_prev_en, m_dcm;
  int         run_now[4];
  int         run_old[4];

  task automatic model_step();
    logic [3:0] stab;
    bit ok, ok_old, leave;
    int st_old, g;
    if (rst) begin
      m_st = 0; m_age = 0; m_retry = 0; m_lost = 0; m_sel = 0; m_prev_sel = 0;
      m_runedges = 0; m_selage = 0; m_dcm = 4'hF; m_cl = 0; m_prev_en = en;
      for (int i = 0; i < 4; i++) begin run_now[i] = 0; run_old[i] = 0; end
      return;
    end
    // A lock counts as stable once raw has been seen high for STAB+1 samples,
    // one sample of which is still in flight through the synchroniser.
    for (int i = 0; i < 4; i++) stab[i] = (run_old[i] >= STAB + 1);
    ok     = &(stab | ~en);
    ok_old = &(stab | ~m_prev_en);
    st_old = m_st;
    case (m_st)
      0: if (en == 4'h0) m_age = 0;
         else if (m_age == HOLD - 1) begin m_st = 1; m_age = 0; end
         else m_age++;
      1: if (ok) begin m_st = 2; m_retry = 0; m_age = 0; end
         else if (m_age == TOUT - 1) begin
           m_retry++; m_age = 0; m_st = (m_retry == MRET) ? 3 : 0;
         end else m_age++;
      2: begin
           leave = !ok_old || (en != m_prev_en) || restart;
           if (!ok_old && m_lost < 255) m_lost++;
           if (leave) begin m_st = 0; m_age = 0; end
         end
      default: if (restart) begin m_retry = 0; m_st = 0; m_age = 0; end
    endcase
    m_runedges = (st_old == 2) ? m_runedges + 1 : 0;
    m_selage   = (selr[0] == m_prev_sel) ? ((m_selage < 1000) ? m_selage + 1 : m_selage) : 0;
    g = (m_runedges < m_selage) ? m_runedges : m_selage;
    if (st_old == 2 && selr[0] != m_sel && g == GAP - 1) m_sel = selr[0];
    m_dcm = (m_st == 0 || m_st == 3) ? 4'hF : ~en;
    m_cl  = (m_st == 2);
    m_prev_en  = en;
    m_prev_sel = selr[0];
    for (int i = 0; i < 4; i++) begin
      run_old[i] = run_now[i];
      run_now[i] = lk[i] ? ((run_now[i] < 100000) ? run_now[i] + 1 : run_now[i]) : 0;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    total++;
    if (st !== 2'(m_st) || dcm !== m_dcm || cl !== m_cl || fsel[0] !== m_sel ||
        rc !== 2'(m_retry) || lc !== 8'(m_lost)) begin
      bad++;
      $display("FAIL model t=%0t got st=%0d dcm=%h cl=%0d sel=%0d rc=%0d lc=%0d exp st=%0d dcm=%h cl=%0d sel=%0d rc=%0d lc=%0d",
               $time, st, dcm, cl, fsel, rc, lc, m_st, m_dcm, m_cl, m_sel, m_retry, m_lost);
    end
  endtask

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic wait_state(input int target, input int budget, output bit hit);
    hit = 0;
    for (int i = 0; i < budget && !hit; i++) begin
      tick();
      if (st == 2'(target)) hit = 1;
    end
  endtask

  typedef struct {
    bit         rst;
    logic [3:0] en;
    logic [3:0] lk;
    bit         rs;
    int         n;
    int         e_st, e_dcm, e_cl, e_rc, e_lc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit r, logic [3:0] e, logic [3:0] l, bit rs, int n,
                              int est, int edcm, int ecl, int erc, int elc);
    vec_t v;
    v.rst = r; v.en = e; v.lk = l; v.rs = rs; v.n = n;
    v.e_st = est; v.e_dcm = edcm; v.e_cl = ecl; v.e_rc = erc; v.e_lc = elc;
    return v;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hit;
    int n, misses;
    int dead[4];
    rst = 1; en = 4'hF; lk = 4'h0; restart = 0; selr = 1'b0;

    // Nominal lock-up; locks rise five cycles after dcm_rst falls.
    tbl.push_back(mk(1, 4'hF, 4'h0, 0,  2, 0, 15, 0, 0, 0));
    tbl.push_back(mk(0, 4'hF, 4'h0, 0,  7, 0, 15, 0, 0, 0));
    tbl.push_back(mk(0, 4'hF, 4'h0, 0,  1, 1,  0, 0, 0, 0));
    tbl.push_back(mk(0, 4'hF, 4'h0, 0,  4, 1,  0, 0, 0, 0));
    tbl.push_back(mk(0, 4'hF, 4'hF, 0, 18, 1,  0, 0, 0, 0));
    tbl.push_back(mk(0, 4'hF, 4'hF, 0,  1, 2,  0, 1, 0, 0));
    // Generator 2 never locks: three timeouts into FAIL, then restart.
    tbl.push_back(mk(1, 4'hF, 4'hB, 0,  1, 0, 15, 0, 0, 0));
    tbl.push_back(mk(0, 4'hF, 4'hB, 0,  8, 1,  0, 0, 0, 0));
    tbl.push_back(mk(0, 4'hF, 4'hB, 0, 63, 1,  0, 0, 0, 0));
    tbl.push_back(mk(0, 4'hF, 4'hB, 0,  1, 0, 15, 0, 1, 0));
    tbl.push_back(mk(0, 4'hF, 4'hB, 0,  8, 1,  0, 0, 1, 0));
    tbl.push_back(mk(0, 4'hF, 4'hB, 0, 64, 0, 15, 0, 2, 0));
    tbl.push_back(mk(0, 4'hF, 4'hB, 0,  8, 1,  0, 0, 2, 0));
    tbl.push_back(mk(0, 4'hF, 4'hB, 0, 63, 1,  0, 0, 2, 0));
    tbl.push_back(mk(0, 4'hF, 4'hB, 0,  1, 3, 15, 0, 3, 0));
    tbl.push_back(mk(0, 4'hF, 4'hB, 0, 20, 3, 15, 0, 3, 0));
    tbl.push_back(mk(0, 4'hF, 4'hB, 1,  1, 0, 15, 0, 0, 0));
    tbl.push_back(mk(0, 4'hF, 4'hB, 0,  8, 1,  0, 0, 0, 0));
    // Partial mask, then a mask change in RUN.
    tbl.push_back(mk(1, 4'h3, 4'h3, 0,  1, 0, 15, 0, 0, 0));
    tbl.push_back(mk(0, 4'h3, 4'h3, 0,  7, 0, 15, 0, 0, 0));
    tbl.push_back(mk(0, 4'h3, 4'h3, 0,  1, 1, 12, 0, 0, 0));
    tbl.push_back(mk(0, 4'h3, 4'h3, 0, 10, 1, 12, 0, 0, 0));
    tbl.push_back(mk(0, 4'h3, 4'h3, 0,  1, 2, 12, 1, 0, 0));
    tbl.push_back(mk(0, 4'h7, 4'h3, 0,  1, 0, 15, 0, 0, 0));
    tbl.push_back(mk(0, 4'h7, 4'h3, 0,  8, 1,  8, 0, 0, 0));

    foreach (tbl[k]) begin
      rst = tbl[k].rst; en = tbl[k].en; lk = tbl[k].lk; restart = tbl[k].rs;
      repeat (tbl[k].n) tick();
      chk($sformatf("vec%0d_state", k), int'(st), tbl[k].e_st);
      chk($sformatf("vec%0d_dcm", k), int'(dcm), tbl[k].e_dcm);
      chk($sformatf("vec%0d_locked", k), int'(cl), tbl[k].e_cl);
      chk($sformatf("vec%0d_retry", k), int'(rc), tbl[k].e_rc);
      chk($sformatf("vec%0d_lost", k), int'(lc), tbl[k].e_lc);
    end
    restart = 0;

    // Single-cycle lock glitch in RUN.
    rst = 1; en = 4'hF; lk = 4'hF; tick(); rst = 0;
    wait_state(2, 100, hit); chk("glitch_reach_run", int'(hit), 1);
    lk = 4'b1101; tick(); lk = 4'hF; n = 1;
    while (cl && n < 8) begin tick(); n++; end
    chk("glitch_latency_le3", int'(n <= 3), 1);
    chk("glitch_lost", int'(lc), 1);
    wait_state(2, 100, hit); chk("glitch_resequence", int'(hit), 1);

    // Select commit after four stable cycles; toggling never commits.
    selr = 1'b1; repeat (3) tick(); chk("sel_not_yet", int'(fsel), 0);
    tick(); chk("sel_commit", int'(fsel), 1);
    for (int p = 0; p < 6; p++) begin
      selr = 1'(p % 2 == 0 ? 0 : 1); repeat (2) tick();
      chk("sel_toggle_hold", int'(fsel), 1);
    end
    // Request changed outside RUN commits only after RUN has lasted long enough.
    restart = 1; tick(); restart = 0; chk("restart_in_run", int'(st), 0);
    selr = 1'b0;
    wait_state(2, 100, hit); chk("sel_reach_run", int'(hit), 1);
    chk("sel_held_outside_run", int'(fsel), 1);
    repeat (2) tick(); chk("sel_wait_run", int'(fsel), 1);
    tick(); chk("sel_commit_after_run", int'(fsel), 0);

    // Reset in RUN and mid-WAIT_LOCK.
    selr = 1'b1; repeat (4) tick(); chk("sel_before_rst", int'(fsel), 1);
    rst = 1; tick(); rst = 0;
    chk("rst_run_state", int'(st), 0);
    chk("rst_run_dcm", int'(dcm), 15);
    chk("rst_run_locked", int'(cl), 0);
    chk("rst_run_sel", int'(fsel), 0);
    chk("rst_run_lost", int'(lc), 0);
    lk = 4'h0;
    wait_state(1, 40, hit); chk("reach_wait", int'(hit), 1);
    repeat (70) tick(); chk("retry_before_rst", int'(rc), 1);
    repeat (20) tick();
    rst = 1; tick(); rst = 0;
    chk("rst_wait_state", int'(st), 0);
    chk("rst_wait_retry", int'(rc), 0);
    chk("rst_wait_dcm", int'(dcm), 15);

    // Lost counter saturation.
    lk = 4'hF; misses = 0;
    for (int k = 0; k < 300; k++) begin
      wait_state(2, 100, hit);
      if (!hit) misses++;
      lk = 4'b1110; tick(); lk = 4'hF; tick();
    end
    repeat (3) tick();
    chk("loss_loop_runs", misses, 0);
    chk("lost_saturated", int'(lc), 255);

    // Random stimulus against the model.
    rst = 1; en = 4'hF; lk = 4'hF; tick(); rst = 0;
    for (int i = 0; i < 4; i++) dead[i] = 0;
    for (int c = 0; c < 4000; c++) begin
      rst     = ($urandom_range(0, 499) == 0);
      restart = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 199) == 0) en = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) selr = 1'($urandom_range(0, 1));
      for (int i = 0; i < 4; i++) begin
        if (dead[i] > 0) begin dead[i]--; lk[i] = 1'b0; end
        else if ($urandom_range(0, 399) == 0) begin dead[i] = $urandom_range(50, 250); lk[i] = 1'b0; end
        else if (!lk[i]) lk[i] = ($urandom_range(0, 3) == 0);
        else lk[i] = ($urandom_range(0, 149) != 0);
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
